// File: rtl/ame_num_normal_vec.sv
// ---------------------------------------------------------------------------
// ame_num_normal_vec
//
// Multi-lane right-shift normaliser. A job latches LANES integers of
// DATA_BITS each, a common shift amount and mode bits. One shared shifter
// then processes one lane per cycle. Each lane is shifted (arithmetic or
// logical), optionally rounded half-up and range-checked against OUT_BITS,
// then saturated or truncated.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   comp_init_i   start request (accepted in IDLE or DONE)
//   comp_busy_o   high in RUN and DONE
//   comp_done_o   one-cycle pulse, results valid
//   comp_arith_i  1 = arithmetic shift / signed range, 0 = logical / unsigned
//   comp_round_i  round half-up (ignored for shift 0)
//   comp_sat_i    saturate out-of-range lanes to the nearest bound
//   comp_shift_i  shift amount, common to all lanes
//   comp_data_i   lane k at [k*DATA_BITS +: DATA_BITS]
//   comp_data_o   lane k at [k*OUT_BITS +: OUT_BITS]
//   comp_ovf_o    per-lane out-of-range flag
//   fsm_state     controller state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: comp_init_i is a level sampled on every rising edge. It is
// accepted only in IDLE or DONE; in RUN it is ignored. Acceptance latches
// all inputs at that edge. comp_done_o rises LANES+1 cycles after the
// accepting edge for exactly one cycle. comp_data_o/comp_ovf_o are stable
// from that cycle until the first lane of the next job is written.
// ---------------------------------------------------------------------------
module ame_num_normal_vec #(
    parameter int DATA_BITS = 64,
    parameter int OUT_BITS  = 32,
    parameter int LANES     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          comp_init_i,
    output logic                          comp_busy_o,
    output logic                          comp_done_o,
    input  logic                          comp_arith_i,
    input  logic                          comp_round_i,
    input  logic                          comp_sat_i,
    input  logic [$clog2(DATA_BITS)-1:0]  comp_shift_i,
    input  logic [LANES*DATA_BITS-1:0]    comp_data_i,
    output logic [LANES*OUT_BITS-1:0]     comp_data_o,
    output logic [LANES-1:0]              comp_ovf_o,
    output logic [1:0]                    fsm_state
);

    localparam int SHIFT_BITS = $clog2(DATA_BITS);
    localparam int CNT_BITS   = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      accept;
    logic [CNT_BITS-1:0]       cnt;
    logic                      last_lane;

    logic [LANES*DATA_BITS-1:0] data_q;
    logic [SHIFT_BITS-1:0]      shift_q;
    logic                       arith_q;
    logic                       round_q;
    logic                       sat_q;

    // lane datapath
    logic [DATA_BITS-1:0] lane_x;
    logic [DATA_BITS-1:0] shift_arith;
    logic [DATA_BITS-1:0] shift_logic;
    logic [DATA_BITS-1:0] shifted;
    logic                 round_bit;
    logic [DATA_BITS-1:0] rounded;
    logic [DATA_BITS-1:0] upper_s;
    logic [DATA_BITS-1:0] upper_u;
    logic                 lane_ovf;
    logic [OUT_BITS-1:0]  bound;
    logic [OUT_BITS-1:0]  lane_y;

    assign fsm_state = state;
    assign last_lane = (cnt == CNT_BITS'(LANES - 1));

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (comp_init_i) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (comp_init_i) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Shared lane datapath, operating on lane `cnt` of the latched job
    // ---------------------------------------------------------------------
    always_comb begin
        lane_x = data_q[cnt*DATA_BITS +: DATA_BITS];
        // The two shifts are kept as separate statements so the arithmetic
        // shift keeps its signed operand instead of being coerced to unsigned
        // inside a conditional expression.
        shift_arith = $signed(lane_x) >>> shift_q;
        shift_logic = lane_x >> shift_q;
        shifted     = arith_q ? shift_arith : shift_logic;

        // Half-up rounding adds the last bit shifted out. With s >= 1 the
        // magnitude of the shifted value has headroom, so no carry is lost.
        round_bit = 1'b0;
        if (round_q && (shift_q != '0)) begin
            round_bit = lane_x[shift_q - 1'b1];
        end
        rounded = shifted + {{(DATA_BITS-1){1'b0}}, round_bit};

        // Signed range holds when all bits from OUT_BITS-1 upward equal the
        // sign; unsigned range holds when all bits from OUT_BITS upward are 0.
        upper_s = $signed(rounded) >>> (OUT_BITS - 1);
        upper_u = rounded >> OUT_BITS;
        if (arith_q) begin
            lane_ovf = (upper_s != '0) && (upper_s != '1);
        end else begin
            lane_ovf = (upper_u != '0);
        end

        if (arith_q) begin
            bound = rounded[DATA_BITS-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                         : {1'b0, {(OUT_BITS-1){1'b1}}};
        end else begin
            bound = '1;
        end

        lane_y = (sat_q && lane_ovf) ? bound : rounded[OUT_BITS-1:0];
    end

    // ---------------------------------------------------------------------
    // State, job registers and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            data_q      <= '0;
            shift_q     <= '0;
            arith_q     <= 1'b0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            comp_data_o <= '0;
            comp_ovf_o  <= '0;
            comp_busy_o <= 1'b0;
            comp_done_o <= 1'b0;
        end else begin
            state       <= state_next;
            comp_busy_o <= (state_next != IDLE);
            comp_done_o <= (state_next == DONE);
            if (accept) begin
                data_q  <= comp_data_i;
                shift_q <= comp_shift_i;
                arith_q <= comp_arith_i;
                round_q <= comp_round_i;
                sat_q   <= comp_sat_i;
                cnt     <= '0;
            end else if (state == RUN) begin
                comp_data_o[cnt*OUT_BITS +: OUT_BITS] <= lane_y;
                comp_ovf_o[cnt]                       <= lane_ovf;
                cnt                                   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ame_num_normal_vec.sv
// ---------------------------------------------------------------------------
// Bench for ame_num_normal_vec (DATA_BITS=64, OUT_BITS=32, LANES=4).
// Expected lanes come from a reference model using integer division by
// powers of two on a wide signed value, then the range/saturation rules.
// ---------------------------------------------------------------------------
module tb_ame_num_normal_vec;

    localparam int DB = 64;
    localparam int OB = 32;
    localparam int NL = 4;

    logic              clk;
    logic              rst;
    logic              init;
    logic              busy;
    logic              done;
    logic              arith;
    logic              rnd;
    logic              sat;
    logic [5:0]        shift;
    logic [NL*DB-1:0]  data_in;
    logic [NL*OB-1:0]  data_out;
    logic [NL-1:0]     ovf;
    logic [1:0]        fsm_state;

    int errors = 0;
    int checks = 0;

    // scoreboard: one entry per lane, {ovf, value}
    logic [OB:0] exp_q[$];
    logic [OB-1:0] got_y[NL];
    logic          got_ovf[NL];

    ame_num_normal_vec #(.DATA_BITS(DB), .OUT_BITS(OB), .LANES(NL)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .comp_init_i  (init),
        .comp_busy_o  (busy),
        .comp_done_o  (done),
        .comp_arith_i (arith),
        .comp_round_i (rnd),
        .comp_sat_i   (sat),
        .comp_shift_i (shift),
        .comp_data_i  (data_in),
        .comp_data_o  (data_out),
        .comp_ovf_o   (ovf),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [OB:0] model(input logic [DB-1:0] x, input int s,
                                          input bit a, input bit r, input bit st);
        logic signed [71:0] v, den, num, q, hi, lo;
        bit o;
        logic [OB-1:0] y;
        v   = a ? $signed({{8{x[DB-1]}}, x}) : $signed({8'b0, x});
        den = 72'sd1;
        for (int i = 0; i < s; i++) den = den * 72'sd2;
        num = v;
        if (r && s != 0) num = v + den / 72'sd2;
        q = num / den;
        if (q * den > num) q = q - 72'sd1;   // floor for negative values
        if (a) begin
            hi = 72'sd2147483647;
            lo = -72'sd2147483648;
        end else begin
            hi = 72'sd4294967295;
            lo = 72'sd0;
        end
        o = (q > hi) || (q < lo);
        if (st && o) y = (q > hi) ? hi[OB-1:0] : lo[OB-1:0];
        else         y = q[OB-1:0];
        return {o, y};
    endfunction

    function automatic logic [NL*DB-1:0] pack(input logic [DB-1:0] l0, input logic [DB-1:0] l1,
                                               input logic [DB-1:0] l2, input logic [DB-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DB-1:0] rand_lane();
        logic [DB-1:0] v;
        logic [31:0]   w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = {{32{w[31]}}, w};
            2: v = {32'h0, w};
            default: v = {{24{w[31]}}, w, 8'h0};
        endcase
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic drive_init(input logic [NL*DB-1:0] d, input int s,
                              input bit a, input bit r, input bit st);
        data_in = d;
        shift   = 6'(s);
        arith   = a;
        rnd     = r;
        sat     = st;
        init    = 1'b1;
        for (int k = 0; k < NL; k++) exp_q.push_back(model(d[k*DB +: DB], s, a, r, st));
        @(negedge clk);
        init    = 1'b0;
        // inputs are free to change once accepted
        data_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        shift   = 6'($urandom_range(0, 63));
        arith   = ~a;
        rnd     = ~r;
        sat     = ~st;
    endtask

    // Waits for done starting at cycle `start` after the accepting edge.
    task automatic wait_done(input string tag, input int start);
        int lat;
        int busy_bad;
        lat = start;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
    endtask

    task automatic check_results(input string tag);
        logic [OB:0] e;
        for (int k = 0; k < NL; k++) begin
            got_y[k]   = data_out[k*OB +: OB];
            got_ovf[k] = ovf[k];
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_y%0d", tag, k), 64'(got_y[k]), 64'(e[OB-1:0]));
                check($sformatf("%s_ovf%0d", tag, k), 64'(got_ovf[k]), 64'(e[OB]));
            end
        end
    endtask

    task automatic run_job(input string tag, input logic [NL*DB-1:0] d, input int s,
                           input bit a, input bit r, input bit st);
        drive_init(d, s, a, r, st);
        wait_done(tag, 1);
        check_results(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) n++;
            @(negedge clk);
        end
        check({tag, "_no_done"}, 64'(n), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; init = 1'b0; arith = 1'b0; rnd = 1'b0; sat = 1'b0;
        shift = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", data_out[63:0], 64'd0);
        check("rst_data_hi", data_out[127:64], 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1. basic arithmetic shift
        run_job("t1", pack(-64'sd256, 64'd256, 64'hFF, -64'sd1), 4, 1, 0, 0);
        check("t1_c0", 64'(got_y[0]), 64'hFFFF_FFF0);
        check("t1_c1", 64'(got_y[1]), 64'h10);
        check("t1_c2", 64'(got_y[2]), 64'hF);
        check("t1_c3", 64'(got_y[3]), 64'hFFFF_FFFF);

        // 2. arithmetic vs logical on a negative lane
        run_job("t2a", pack(64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0), 8, 1, 0, 0);
        check("t2a_c", {31'b0, got_ovf[0], got_y[0]}, {31'b0, 1'b0, 32'hFFFF_FFFF});
        run_job("t2b", pack(64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0), 8, 0, 0, 0);
        check("t2b_c", {31'b0, got_ovf[0], got_y[0]}, {31'b0, 1'b1, 32'hFFFF_FFFF});
        run_job("t2c", pack(64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0), 8, 0, 0, 1);
        check("t2c_c", {31'b0, got_ovf[0], got_y[0]}, {31'b0, 1'b1, 32'hFFFF_FFFF});
        run_job("t2d", pack(64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0), 40, 0, 0, 1);
        check("t2d_c", {31'b0, got_ovf[0], got_y[0]}, {31'b0, 1'b0, 32'h00FF_FFFF});

        // 3. rounding
        run_job("t3", pack(64'd3, -64'sd3, 64'd1, -64'sd1), 1, 1, 1, 0);
        check("t3_c", {got_y[3], got_y[2], got_y[1], got_y[0]},
              {32'h0, 32'h1, 32'hFFFF_FFFF, 32'h2});
        run_job("t3_s0", pack(64'd3, -64'sd3, 64'd1, -64'sd1), 0, 1, 1, 0);
        check("t3_s0_c", {got_y[1], got_y[0]}, {32'hFFFF_FFFD, 32'h3});

        // 4. saturation
        run_job("t4s", pack(64'h1_0000_0000, -64'sh100_0000_0000, 64'h7FFF_FFFF, -64'sh8000_0000), 0, 1, 0, 1);
        check("t4s_c", {got_y[1], got_y[0]}, {32'h8000_0000, 32'h7FFF_FFFF});
        check("t4s_ovf", 64'(ovf), 64'b0011);
        run_job("t4n", pack(64'h1_0000_0000, -64'sh100_0000_0000, 64'h7FFF_FFFF, -64'sh8000_0000), 0, 1, 0, 0);
        check("t4n_c", {got_y[1], got_y[0]}, {32'h0, 32'h0});
        check("t4n_ovf", 64'(ovf), 64'b0011);

        // 5a. init during RUN is ignored
        drive_init(pack(64'd1000, 64'd2000, 64'd3000, 64'd4000), 2, 0, 0, 0);
        @(negedge clk);                       // cycle T+2
        init = 1'b1;
        data_in = pack(64'd7, 64'd7, 64'd7, 64'd7);
        @(negedge clk);                       // cycle T+3
        init = 1'b0;
        wait_done("t5a", 3);
        check_results("t5a");
        @(negedge clk);
        count_done("t5a", 10);

        // 5b. back-to-back via DONE
        drive_init(pack(64'd400, 64'd800, 64'd1200, 64'd1600), 4, 1, 1, 0);
        wait_done("t5b1", 1);
        check_results("t5b1");
        drive_init(pack(-64'sd400, 64'h1234_5678_9ABC, 64'd5, -64'sd9), 3, 1, 1, 1);
        wait_done("t5b2", 1);
        check_results("t5b2");
        @(negedge clk);

        // 6. reset mid-job, with init coincident with reset
        drive_init(pack(64'd11, 64'd22, 64'd33, 64'd44), 1, 0, 0, 0);
        @(negedge clk);                       // cycle T+2
        rst  = 1'b1;
        init = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
        exp_q.delete();
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_data", data_out[127:64] | data_out[63:0], 64'd0);
        check("t6_ovf", 64'(ovf), 64'd0);
        count_done("t6", 10);
        run_job("t6_after", pack(64'd100, -64'sd100, 64'hFFFF_FFFF_FFFF, 64'd7), 3, 1, 1, 1);

        // randomized jobs, alternating isolated and back-to-back starts
        for (int j = 0; j < 40; j++) begin
            drive_init(pack(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
                       $urandom_range(0, 63), 1'($urandom), 1'($urandom), 1'($urandom));
            wait_done($sformatf("rnd%0d", j), 1);
            check_results($sformatf("rnd%0d", j));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ame_num_normal_vec.md
# ame_num_normal_vec

Multi-lane, mode-selectable successor to the single-lane 64-bit arithmetic-shift normaliser in the AME numeric path. It right-shifts a vector of `LANES` integers by a common amount and narrows each result to `OUT_BITS`. Each lane supports arithmetic or logical shift, optional round-half-up, and optional saturation with per-lane overflow flags. One shared shifter processes lanes sequentially, one per cycle, under an init/busy/done handshake.

## Interface
- `DATA_BITS`, 64, input lane width
- `OUT_BITS`, 32, output lane width (≤ `DATA_BITS`)
- `LANES`, 4, lane count (≥ 1)
- `clk_i` in 1: clock, all logic rising-edge
- `rst_i` in 1: reset, synchronous, active-high
- `comp_init_i` in 1: start request, sampled each cycle
- `comp_busy_o` out 1: high while a job is in progress
- `comp_done_o` out 1: one-cycle pulse; results valid
- `comp_arith_i` in 1: 1 = arithmetic shift, signed saturation; 0 = logical shift, unsigned saturation
- `comp_round_i` in 1: enable round-half-up
- `comp_sat_i` in 1: enable saturation to `OUT_BITS`
- `comp_shift_i` in `$clog2(DATA_BITS)`: shift amount, common to all lanes
- `comp_data_i` in `LANES*DATA_BITS`: lane k at bits [k*DATA_BITS +: DATA_BITS]
- `comp_data_o` out `LANES*OUT_BITS`: lane k at bits [k*OUT_BITS +: OUT_BITS]
- `comp_ovf_o` out `LANES`: per-lane out-of-range flag

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN: lane counter 0..LANES-1.
  - DONE: lasts one cycle.
- Job acceptance:
  - In IDLE or DONE, `comp_init_i`=1 latches `comp_data_i`, the shift amount and all mode bits into internal registers, clears the counter and enters RUN.
  - Inputs may change after the accepting edge.
  - `comp_init_i` during RUN is ignored; there is no queueing.
- RUN: each cycle computes lane `cnt` from the latched data, writes its result and flag to the output registers, and increments `cnt`.
  - After lane LANES-1, go to DONE.
- DONE: `comp_done_o`=1. Go to IDLE, or to RUN if `comp_init_i`=1 (back-to-back).
- Per-lane arithmetic, with x = lane input and s = shift amount:
  - Shift result q = x >>> s if arith, else x >> s.
  - Rounding: if round=1 and s≠0, r = q + x[s-1]; otherwise r = q.
  - Arithmetic mode rounds toward +inf on ties.
  - Overflow of r is impossible for s ≥ 1, so r is computed in DATA_BITS.
  - Range check:
    - arith: r outside [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1];
    - logical: r ≥ 2^OUT_BITS.
  - `ovf` = range violation, independent of the sat setting.
  - Output:
    - sat=1 and ovf: the nearest bound;
    - otherwise: r[OUT_BITS-1:0] (truncation).
- Outputs `comp_data_o` / `comp_ovf_o`:
  - During RUN they are partially updated and undefined to consumers.
  - They hold the last job's results from DONE until the next job's first RUN write.

## Timing
- Init sampled at edge T.
  - RUN during cycles T+1..T+LANES.
  - `comp_done_o` high during cycle T+LANES+1 only.
- Latency from init to done: LANES+1 cycles.
- Throughput: one job per LANES+1 cycles, back-to-back via DONE.
- `comp_busy_o` is high in RUN and DONE and low in IDLE.
- Reset values: `comp_busy_o`=0, `comp_done_o`=0, `comp_data_o`=0, `comp_ovf_o`=0, FSM=IDLE, counter=0.
- Reset during RUN or DONE:
  - Aborts the job, with no done pulse.
  - All outputs are 0 on the cycle after the reset edge.
  - `comp_init_i` coincident with `rst_i` is ignored.
- `comp_done_o` is registered; there is no combinational path from inputs to outputs.

## Test plan
Defaults: DATA_BITS=64, OUT_BITS=32, LANES=4.
1. Arith, no round, no sat, s=4, lanes {-256, 256, 0xFF, -1}:
   - outputs {0xFFFF_FFF0, 0x10, 0xF, 0xFFFF_FFFF}, ovf=0000;
   - done exactly 5 cycles after init, busy high cycles 1–5.
2. Lane 0 = 0xFFFF_FFFF_FFFF_FF00, s=8:
   - arith → 0xFFFF_FFFF, ovf=0;
   - logical, no sat → 0xFFFF_FFFF, ovf=1;
   - logical, sat → 0xFFFF_FFFF, ovf=1;
   - logical, sat, s=40 → 0x00FF_FFFF, ovf=0.
3. Rounding, arith, s=1, lanes {3, -3, 1, -1} → {2, 0xFFFF_FFFF, 1, 0}. With s=0 and round=1, lanes pass through unchanged.
4. Saturation, arith, s=0, lanes {2^32, -(2^40), 2^31-1, -(2^31)}:
   - sat=1 → {0x7FFF_FFFF, 0x8000_0000, 0x7FFF_FFFF, 0x8000_0000}, ovf=0011;
   - sat=0 → {0x0, 0x0, 0x7FFF_FFFF, 0x8000_0000}, ovf=0011.
5. Handshake:
   - Init pulsed at T+2 of a running job is ignored; only one done pulse occurs.
   - Init held during the DONE cycle starts a second job; its done follows 5 cycles later with the new data.
6. Reset at T+2 mid-job:
   - next cycle busy=0, done=0, data_o=0, ovf=0;
   - no done pulse follows;
   - a subsequent init completes normally with correct results.
